// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//   Direct-mapped instruction cache with one 32-bit word per line. It sits
//   between the IF stage and memory_control. Hits are served from on-chip
//   tag/data arrays one cycle after acceptance. A miss issues a single word
//   fetch to memory_control and holds the request until the refill pulse
//   returns. The returned word fills the line and is forwarded to IF.
//   Jumps cancel an outstanding fetch, and flush_i (fence.i) invalidates
//   every line.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   jump_i       redirect from the pipeline; cancels an outstanding miss
//   flush_i      invalidate all lines
//   if_req_i     IF fetch request
//   if_pc_i      fetch address; bits [1:0] are ignored
//   if_inst_o    fetched instruction
//   if_valid_o   one-cycle pulse: if_inst_o belongs to the accepted request
//   if_busy_o    high while a miss is outstanding
//   mem_req_o    word fetch request to memory_control
//   mem_addr_o   word address of the fetch
//   mem_data_i   refill data
//   mem_valid_i  refill-complete pulse
//   mem_busy_i   memory_control port held by a data access; not used here
// -----------------------------------------------------------------------------
module inst_cache #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_i,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_busy_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_valid_i,
    input  logic        mem_busy_i
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t                     state;
    logic [LINES-1:0]           valid;
    logic [TAG_BITS-1:0]        tag_arr  [LINES];
    logic [31:0]                data_arr [LINES];
    logic [29:0]                req_pc;

    logic [INDEX_BITS-1:0]      idx;
    logic [TAG_BITS-1:0]        tag;
    logic [INDEX_BITS-1:0]      req_idx;
    logic [TAG_BITS-1:0]        req_tag;
    logic                       hit;
    logic                       accept;
    logic                       fill;

    assign idx     = if_pc_i[INDEX_BITS+1:2];
    assign tag     = if_pc_i[31:INDEX_BITS+2];
    assign req_idx = req_pc[INDEX_BITS-1:0];
    assign req_tag = req_pc[29:INDEX_BITS];
    assign hit     = valid[idx] && (tag_arr[idx] == tag);

    // The if_valid_o term inserts one bubble after every delivered word so
    // that IF's not-yet-updated pc is never accepted a second time.
    assign accept  = (state == IDLE) && if_req_i && !jump_i && !flush_i && !if_valid_o;

    // Any refill that returns while in MISS writes the line, even under a
    // jump: the data is correct for the latched address.
    assign fill    = (state == MISS) && mem_valid_i;

    // Byte-offset bits and the memory busy flag play no part in the logic.
    logic unused_ok;
    assign unused_ok = ^{mem_busy_i, if_pc_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            if_busy_o  <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            req_pc     <= '0;
        end else begin
            if_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            if_inst_o  <= data_arr[idx];
                            if_valid_o <= 1'b1;
                        end else begin
                            req_pc     <= if_pc_i[31:2];
                            mem_addr_o <= {if_pc_i[31:2], 2'b00};
                            mem_req_o  <= 1'b1;
                            if_busy_o  <= 1'b1;
                            state      <= MISS;
                        end
                    end
                end
                MISS: begin
                    // mem_req_o/mem_addr_o stay put until the refill or a jump.
                    if (mem_valid_i) begin
                        if (!jump_i) begin
                            if_inst_o  <= mem_data_i;
                            if_valid_o <= 1'b1;
                        end
                        mem_req_o <= 1'b0;
                        if_busy_o <= 1'b0;
                        state     <= IDLE;
                    end else if (jump_i) begin
                        mem_req_o <= 1'b0;
                        if_busy_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    if_busy_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            // Flush beats a same-cycle fill: the line stays invalid.
            if (flush_i) begin
                valid <= '0;
            end else if (fill) begin
                valid[req_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid vector guards it.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;

    localparam int IB    = 7;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_i, flush_i, if_req_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o, if_busy_o, mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i, mem_busy_i;

    int errors = 0;
    int checks = 0;

    // Reference model: per-line valid/tag/data computed from the address with
    // plain arithmetic.
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] cur_addr;

    inst_cache #(.INDEX_BITS(IB)) dut (
        .clk        (clk),
        .rst        (rst),
        .jump_i     (jump_i),
        .flush_i    (flush_i),
        .if_req_i   (if_req_i),
        .if_pc_i    (if_pc_i),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o),
        .if_busy_o  (if_busy_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_valid_i(mem_valid_i),
        .mem_busy_i (mem_busy_i)
    );

    always #5 clk = ~clk;

    function automatic int unsigned line_of(input logic [31:0] pc);
        return (pc / 4) % LINES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * LINES);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle. want: 1 hit, 0 miss, -1 use model.
    task automatic accept_cycle(input logic [31:0] pc, input int want, output bit was_hit);
        int unsigned l;
        l = line_of(pc);
        if (want < 0) was_hit = m_valid[l] && (m_tag[l] == tag_of(pc));
        else          was_hit = (want == 1);
        if_req_i = 1'b1;
        if_pc_i  = pc;
        tick();
        if_req_i = 1'b0;
        if_pc_i  = $urandom;          // must be ignored while in MISS
        if (was_hit) begin
            chk("hit_valid", {31'd0, if_valid_o}, 32'd1);
            chk("hit_inst", if_inst_o, m_data[l]);
            chk("hit_noreq", {31'd0, mem_req_o}, 32'd0);
        end else begin
            cur_addr = {pc[31:2], 2'b00};
            chk("miss_req", {31'd0, mem_req_o}, 32'd1);
            chk("miss_addr", mem_addr_o, cur_addr);
            chk("miss_busy", {31'd0, if_busy_o}, 32'd1);
            chk("miss_novalid", {31'd0, if_valid_o}, 32'd0);
        end
    endtask

    task automatic wait_cycles(input int n, input bit busy);
        for (int i = 0; i < n; i++) begin
            mem_valid_i = 1'b0;
            mem_busy_i  = busy ? 1'b1 : 1'($urandom_range(0, 1));
            mem_data_i  = $urandom;
            tick();
            chk("hold_req", {31'd0, mem_req_o}, 32'd1);
            chk("hold_addr", mem_addr_o, cur_addr);
            chk("hold_novalid", {31'd0, if_valid_o}, 32'd0);
        end
        mem_busy_i = 1'b0;
    endtask

    task automatic refill(input logic [31:0] pc, input logic [31:0] word);
        mem_valid_i = 1'b1;
        mem_data_i  = word;
        tick();
        mem_valid_i = 1'b0;
        chk("fill_valid", {31'd0, if_valid_o}, 32'd1);
        chk("fill_inst", if_inst_o, word);
        chk("fill_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("fill_busy_low", {31'd0, if_busy_o}, 32'd0);
        m_valid[line_of(pc)] = 1'b1;
        m_tag[line_of(pc)]   = tag_of(pc);
        m_data[line_of(pc)]  = word;
    endtask

    task automatic idle_cycle();
        tick();
        chk("idle_novalid", {31'd0, if_valid_o}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input int want, input int waitc);
        bit h;
        accept_cycle(pc, want, h);
        if (!h) begin
            wait_cycles(waitc, 1'b0);
            refill(pc, word);
        end
        idle_cycle();
    endtask

    initial begin
        bit h;
        logic [31:0] pc;
        rst = 1'b0;
        jump_i = 0; flush_i = 0; if_req_i = 0; if_pc_i = '0;
        mem_data_i = '0; mem_valid_i = 0; mem_busy_i = 0;
        model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_tag[i]  = 0;
            m_data[i] = '0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_busy", {31'd0, if_busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Cold miss, then hit
        fetch(32'h0000_1004, 32'h00A0_0093, 0, 2);
        fetch(32'h0000_1004, 32'h0, 1, 0);

        // Held request: a pulse every second cycle
        if_req_i = 1'b1;
        if_pc_i  = 32'h0000_1004;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_valid", {31'd0, if_valid_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("stream_req", {31'd0, mem_req_o}, 32'd0);
        end
        if_req_i = 1'b0;
        idle_cycle();

        // Conflict on the same line
        fetch(32'h0000_1204, 32'hDEAD_BEEF, 0, 1);
        fetch(32'h0000_1004, 32'h00A0_0093, 0, 0);
        fetch(32'h0000_1004, 32'h0, 1, 0);

        // Jump cancels an outstanding miss
        accept_cycle(32'h0000_2000, 0, h);
        wait_cycles(5, 1'b1);
        jump_i = 1'b1;
        tick();
        jump_i = 1'b0;
        chk("jmp_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("jmp_novalid", {31'd0, if_valid_o}, 32'd0);
        chk("jmp_busy_low", {31'd0, if_busy_o}, 32'd0);
        idle_cycle();
        fetch(32'h0000_2000, 32'h0000_0013, 0, 1);

        // Jump and refill in the same cycle: line filled, no pulse
        accept_cycle(32'h0000_3008, 0, h);
        wait_cycles(1, 1'b0);
        jump_i = 1'b1; mem_valid_i = 1'b1; mem_data_i = 32'h1234_5678;
        tick();
        jump_i = 1'b0; mem_valid_i = 1'b0;
        chk("jv_novalid", {31'd0, if_valid_o}, 32'd0);
        chk("jv_req_low", {31'd0, mem_req_o}, 32'd0);
        m_valid[line_of(32'h3008)] = 1'b1;
        m_tag[line_of(32'h3008)]   = tag_of(32'h3008);
        m_data[line_of(32'h3008)]  = 32'h1234_5678;
        idle_cycle();
        fetch(32'h0000_3008, 32'h0, 1, 0);
        chk("jv_hit_data", if_inst_o, 32'h1234_5678);

        // Jump while idle: request not accepted
        if_req_i = 1'b1; if_pc_i = 32'h0000_1004; jump_i = 1'b1;
        tick();
        if_req_i = 1'b0; jump_i = 1'b0;
        chk("jidle_novalid", {31'd0, if_valid_o}, 32'd0);
        chk("jidle_noreq", {31'd0, mem_req_o}, 32'd0);

        // Stray refill pulse while idle is ignored
        mem_valid_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
        tick();
        mem_valid_i = 1'b0;
        chk("stray_novalid", {31'd0, if_valid_o}, 32'd0);
        chk("stray_noreq", {31'd0, mem_req_o}, 32'd0);
        fetch(32'h0000_1004, 32'h0, 1, 0);

        // Flush in IDLE
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        model_clear();
        fetch(32'h0000_1004, 32'h00A0_0093, 0, 1);

        // Flush coinciding with a refill: forwarded, but line stays invalid
        accept_cycle(32'h0000_4010, 0, h);
        flush_i = 1'b1; mem_valid_i = 1'b1; mem_data_i = 32'hCAFE_0001;
        tick();
        flush_i = 1'b0; mem_valid_i = 1'b0;
        chk("fl_valid", {31'd0, if_valid_o}, 32'd1);
        chk("fl_inst", if_inst_o, 32'hCAFE_0001);
        model_clear();
        idle_cycle();
        fetch(32'h0000_4010, 32'hCAFE_0002, 0, 0);
        fetch(32'h0000_1004, 32'h00A0_0093, 0, 0);

        // Asynchronous reset in the middle of a miss
        accept_cycle(32'h0000_5000, 0, h);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_req_low", {31'd0, mem_req_o}, 32'd0);
        chk("arst_busy_low", {31'd0, if_busy_o}, 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        mem_valid_i = 1'b1; mem_data_i = 32'hBAD0_BAD0;
        tick();
        mem_valid_i = 1'b0;
        chk("arst_novalid", {31'd0, if_valid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        tick();
        fetch(32'h0000_1004, 32'h00A0_0093, 0, 0);
        fetch(32'h0000_5000, 32'h0000_5555, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            pc = (32'($urandom_range(0, 3)) << (2 + IB)) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3)) | 32'h0001_0000;
            if ($urandom_range(0, 15) == 0) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                model_clear();
            end
            fetch(pc, $urandom, -1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
